// File: rtl/servo_channel_arbiter.sv
// -----------------------------------------------------------------------------
// servo_channel_arbiter
//
// Purpose:
//   Drives N_CH servo PWM outputs. Each channel performs one fixed-length
//   "movement" (MOVE_PERIODS PWM periods of COUNT_LIMIT ticks, high for
//   DUTY_CYCLE ticks at the start of each period) per rising enable. The
//   channels are shared between two masters, a scanner and a user
//   controller. The arbiter hands ownership over only once every channel
//   has finished its movement, so a movement is never cut short by a
//   change of owner.
//
// Parameters:
//   N_CH          number of servo channels
//   COUNT_LIMIT   PWM period in ticks
//   DUTY_CYCLE    high ticks per PWM period
//   MOVE_PERIODS  PWM periods per movement
//   PRESCALE      sys clocks per tick (1 = tick every cycle)
//   DRAIN_TIMEOUT ticks a pending switch may wait before in-flight
//                 movements are aborted (only with SERVO_ARB_FORCE_SWITCH_EN)
//
// Optional feature:
//   SERVO_ARB_FORCE_SWITCH_EN  when defined, a switch waiting DRAIN_TIMEOUT
//                              ticks aborts all moving channels (PWM low,
//                              no done pulse) and then changes owner. When
//                              undefined the switch waits indefinitely.
//
// Ports:
//   I_sys_clk      clock, rising edge
//   I_rst_n        asynchronous active-low reset
//   I_sel_req      requested owner (0 scanner, 1 user controller)
//   I_scan_en      scanner per-channel movement enables
//   I_user_en      user controller per-channel movement enables
//   o_servo_pwm    registered PWM outputs
//   o_scan_done    one-cycle movement-done pulses to the scanner
//   o_user_done    one-cycle movement-done pulses to the user controller
//   o_owner        current owner (same encoding as I_sel_req)
//   o_switch_busy  high while an ownership change is pending (DRAIN)
// -----------------------------------------------------------------------------
module servo_channel_arbiter #(
    parameter int N_CH         = 8,
    parameter int COUNT_LIMIT  = 6429,
    parameter int DUTY_CYCLE   = 3,
    parameter int MOVE_PERIODS = 50,
    parameter int PRESCALE     = 1
`ifdef SERVO_ARB_FORCE_SWITCH_EN
    ,
    parameter int DRAIN_TIMEOUT = 1000
`endif
) (
    input  logic            I_sys_clk,
    input  logic            I_rst_n,
    input  logic            I_sel_req,
    input  logic [N_CH-1:0] I_scan_en,
    input  logic [N_CH-1:0] I_user_en,
    output logic [N_CH-1:0] o_servo_pwm,
    output logic [N_CH-1:0] o_scan_done,
    output logic [N_CH-1:0] o_user_done,
    output logic            o_owner,
    output logic            o_switch_busy
);

    localparam int CW = (COUNT_LIMIT > 1)  ? $clog2(COUNT_LIMIT)  : 1;
    localparam int IW = (MOVE_PERIODS > 1) ? $clog2(MOVE_PERIODS) : 1;
    localparam int PW = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'd0,
        CH_MOVING   = 2'd1,
        CH_WAIT_LOW = 2'd2
    } ch_state_e;

    typedef enum logic [1:0] {
        ARB_OWN_SCAN = 2'd0,
        ARB_DRAIN    = 2'd1,
        ARB_OWN_USER = 2'd2
    } arb_state_e;

    // ------------------------------------------------------------------
    // Shared tick prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    // With PRESCALE=1 the counter sits at 0 and every cycle is a tick.
    assign tick    = (presc_q == PW'(PRESCALE - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    // ------------------------------------------------------------------
    // Arbiter state and effective enables
    // ------------------------------------------------------------------
    arb_state_e      arb_q, arb_d;
    logic            owner_q, owner_d;
    logic [N_CH-1:0] en_eff;
    logic [N_CH-1:0] moving;
    logic            any_moving;
    logic            abort;

    // Enables are masked while draining so no new movement can start and
    // channels parked in WAIT_LOW fall back to IDLE.
    assign en_eff     = (arb_q == ARB_DRAIN) ? '0 : (owner_q ? I_user_en : I_scan_en);
    assign any_moving = |moving;

`ifdef SERVO_ARB_FORCE_SWITCH_EN
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

    logic [DW-1:0] drain_cnt_q, drain_cnt_d;

    always_comb begin
        drain_cnt_d = drain_cnt_q;
        if (arb_q != ARB_DRAIN) begin
            drain_cnt_d = '0;
        end else if (tick && (drain_cnt_q != DW'(DRAIN_TIMEOUT))) begin
            drain_cnt_d = drain_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            drain_cnt_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Fires on the tick that completes DRAIN_TIMEOUT ticks of draining.
    // A request that has already fallen back to the current owner wins.
    assign abort = (arb_q == ARB_DRAIN) && (I_sel_req != owner_q) && tick &&
                   (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1));
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        arb_d   = arb_q;
        owner_d = owner_q;
        case (arb_q)
            ARB_OWN_SCAN: if (I_sel_req)  arb_d = ARB_DRAIN;
            ARB_OWN_USER: if (!I_sel_req) arb_d = ARB_DRAIN;
            ARB_DRAIN: begin
                if (I_sel_req == owner_q) begin
                    arb_d = owner_q ? ARB_OWN_USER : ARB_OWN_SCAN;
                end else if (!any_moving || abort) begin
                    owner_d = I_sel_req;
                    arb_d   = I_sel_req ? ARB_OWN_USER : ARB_OWN_SCAN;
                end
            end
            default: arb_d = ARB_OWN_SCAN;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel movement FSMs
    // ------------------------------------------------------------------
    logic [N_CH-1:0] pwm_d;
    logic [N_CH-1:0] done_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ch_state_e     st_q, st_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [IW-1:0] idx_q, idx_d;
        logic          fin;

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            idx_d = idx_q;
            fin   = 1'b0;
            case (st_q)
                CH_IDLE: begin
                    if (en_eff[g]) begin
                        st_d  = CH_MOVING;
                        cnt_d = '0;
                        idx_d = '0;
                    end
                end
                CH_MOVING: begin
                    // Enable is ignored here: a started movement always runs out
                    // unless the forced switch aborts it.
                    if (abort) begin
                        st_d  = CH_IDLE;
                        cnt_d = '0;
                        idx_d = '0;
                    end else if (tick) begin
                        if (cnt_q == CW'(COUNT_LIMIT - 1)) begin
                            cnt_d = '0;
                            if (idx_q == IW'(MOVE_PERIODS - 1)) begin
                                st_d  = CH_WAIT_LOW;
                                idx_d = '0;
                                fin   = 1'b1;
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                CH_WAIT_LOW: begin
                    if (!en_eff[g]) st_d = CH_IDLE;
                end
                default: st_d = CH_IDLE;
            endcase
        end

        always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
            if (!I_rst_n) begin
                st_q  <= CH_IDLE;
                cnt_q <= '0;
                idx_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                idx_q <= idx_d;
            end
        end

        assign moving[g] = (st_q == CH_MOVING);
        assign done_d[g] = fin;
        // PWM register is loaded from next-state so it lines up with the
        // channel state it describes.
        assign pwm_d[g]  = (st_d == CH_MOVING) && (int'(cnt_d) < DUTY_CYCLE);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [N_CH-1:0] pwm_q, scan_done_q, user_done_q;

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            presc_q     <= '0;
            arb_q       <= ARB_OWN_SCAN;
            owner_q     <= 1'b0;
            pwm_q       <= '0;
            scan_done_q <= '0;
            user_done_q <= '0;
        end else begin
            presc_q     <= presc_d;
            arb_q       <= arb_d;
            owner_q     <= owner_d;
            pwm_q       <= pwm_d;
            // owner_q has not changed yet on a completing edge, so pulses
            // finishing during DRAIN still go to the old owner.
            scan_done_q <= owner_q ? '0 : done_d;
            user_done_q <= owner_q ? done_d : '0;
        end
    end

    assign o_servo_pwm   = pwm_q;
    assign o_scan_done   = scan_done_q;
    assign o_user_done   = user_done_q;
    assign o_owner       = owner_q;
    assign o_switch_busy = (arb_q == ARB_DRAIN);

endmodule

// File: tb/tb_servo_channel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_servo_channel_arbiter
//
// Bench for servo_channel_arbiter with N_CH=4, PRESCALE=1, COUNT_LIMIT=10,
// DUTY_CYCLE=3, MOVE_PERIODS=2. A reference model tracks each movement by
// its start cycle and derives PWM/done from elapsed time; a compare process
// checks every output on each falling edge. Directed scenarios add literal
// expectations (pulse counts, completion cycle, owner changes).
// -----------------------------------------------------------------------------
module tb_servo_channel_arbiter;

  localparam int N_CH         = 4;
  localparam int COUNT_LIMIT  = 10;
  localparam int DUTY_CYCLE   = 3;
  localparam int MOVE_PERIODS = 2;
  localparam int PRESCALE     = 1;
  localparam int MOVE_LEN     = COUNT_LIMIT * MOVE_PERIODS;
`ifdef SERVO_ARB_FORCE_SWITCH_EN
  localparam int DRAIN_TIMEOUT = 4;
`endif

  // ---------------- clock / reset ----------------
  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic            sel_req = 1'b0;
  logic [N_CH-1:0] scan_en = '0;
  logic [N_CH-1:0] user_en = '0;
  logic [N_CH-1:0] o_servo_pwm;
  logic [N_CH-1:0] o_scan_done;
  logic [N_CH-1:0] o_user_done;
  logic            o_owner;
  logic            o_switch_busy;

  always #5 clk = ~clk;

  servo_channel_arbiter #(
    .N_CH         (N_CH),
    .COUNT_LIMIT  (COUNT_LIMIT),
    .DUTY_CYCLE   (DUTY_CYCLE),
    .MOVE_PERIODS (MOVE_PERIODS),
    .PRESCALE     (PRESCALE)
`ifdef SERVO_ARB_FORCE_SWITCH_EN
    ,
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
`endif
  ) dut (
    .I_sys_clk    (clk),
    .I_rst_n      (rst_n),
    .I_sel_req    (sel_req),
    .I_scan_en    (scan_en),
    .I_user_en    (user_en),
    .o_servo_pwm  (o_servo_pwm),
    .o_scan_done  (o_scan_done),
    .o_user_done  (o_user_done),
    .o_owner      (o_owner),
    .o_switch_busy(o_switch_busy)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int              cyc = 0;
  int              m_start [N_CH];  // cycle the movement began, -1 if not moving
  bit              m_wait  [N_CH];  // movement finished, waiting for enable low
  bit              m_owner = 1'b0;
  bit              m_drain = 1'b0;
  int              m_drain_start = 0;
  logic [N_CH-1:0] m_pwm   = '0;
  logic [N_CH-1:0] m_sdone = '0;
  logic [N_CH-1:0] m_udone = '0;
  bit              any_mov;
  bit              abort_m;
  logic [N_CH-1:0] en_m;

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_start[i] = -1;
      m_wait[i]  = 1'b0;
    end
    m_owner = 1'b0;
    m_drain = 1'b0;
    m_drain_start = 0;
    m_pwm   = '0;
    m_sdone = '0;
    m_udone = '0;
  endtask

  task automatic model_step();
    cyc++;
    any_mov = 1'b0;
    for (int i = 0; i < N_CH; i++) if (m_start[i] >= 0) any_mov = 1'b1;
    en_m    = m_drain ? '0 : (m_owner ? user_en : scan_en);
    abort_m = 1'b0;
`ifdef SERVO_ARB_FORCE_SWITCH_EN
    abort_m = m_drain && (sel_req != m_owner) && ((cyc - m_drain_start) == DRAIN_TIMEOUT);
`endif
    m_sdone = '0;
    m_udone = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (m_start[i] >= 0) begin
        if (abort_m) begin
          m_start[i] = -1;
        end else if ((cyc - m_start[i]) == MOVE_LEN) begin
          m_start[i] = -1;
          m_wait[i]  = 1'b1;
          if (m_owner) m_udone[i] = 1'b1;
          else         m_sdone[i] = 1'b1;
        end
      end else if (m_wait[i]) begin
        if (!en_m[i]) m_wait[i] = 1'b0;
      end else if (en_m[i]) begin
        m_start[i] = cyc;
      end
    end
    if (!m_drain) begin
      if (sel_req != m_owner) begin
        m_drain       = 1'b1;
        m_drain_start = cyc;
      end
    end else if (sel_req == m_owner) begin
      m_drain = 1'b0;
    end else if (!any_mov || abort_m) begin
      m_drain = 1'b0;
      m_owner = sel_req;
    end
    for (int i = 0; i < N_CH; i++)
      m_pwm[i] = (m_start[i] >= 0) && (((cyc - m_start[i]) % COUNT_LIMIT) < DUTY_CYCLE);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  task automatic compare_outputs();
    check("pwm",       o_servo_pwm,   m_pwm);
    check("scan_done", o_scan_done,   m_sdone);
    check("user_done", o_user_done,   m_udone);
    check("owner",     o_owner,       m_owner);
    check("busy",      o_switch_busy, m_drain);
  endtask

  always @(negedge clk) if (cmp_en) compare_outputs();

  // ---------------- driver helpers ----------------
  task automatic run_count(input int n, output int pw, output int sd, output int ud);
    pw = 0; sd = 0; ud = 0;
    repeat (n) begin
      @(negedge clk);
      pw += $countones(o_servo_pwm);
      sd += $countones(o_scan_done);
      ud += $countones(o_user_done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, pw, sd, ud;
    bit got;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm",   o_servo_pwm,   0);
    check("rst_owner", o_owner,       0);
    check("rst_busy",  o_switch_busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Held scanner enable: exactly one movement, 3 high of every 10 cycles.
    scan_en = 4'b0001;
    run_count(40, pw, sd, ud);
    check("t1_pwm_high_cycles", pw, 6);
    check("t1_scan_done_count", sd, 1);
    check("t1_user_done_count", ud, 0);
    scan_en = '0;
    repeat (2) @(negedge clk);
    scan_en = 4'b0001;
    @(negedge clk);
    check("t1_restart_pwm", o_servo_pwm, 4'b0001);
    repeat (22) @(negedge clk);
    scan_en = '0;
    repeat (2) @(negedge clk);

    // User enables ignored while scanner owns the channels.
    user_en = 4'b1111;
    run_count(30, pw, sd, ud);
    check("t2_pwm_high_cycles", pw, 0);
    check("t2_done_count", sd + ud, 0);
    user_en = '0;
    repeat (2) @(negedge clk);

    // Switch request mid-movement on channel 2: drain, then hand over.
    scan_en = 4'b0100;
    k = 0; got = 1'b0; ud = 0;
    repeat (5) begin @(negedge clk); k++; end
    sel_req = 1'b1;
    @(negedge clk); k++;
    check("t3_busy",      o_switch_busy, 1);
    check("t3_owner_old", o_owner,       0);
    while (!got && k < 60) begin
      @(negedge clk); k++;
      ud += $countones(o_user_done);
      if (o_scan_done[2]) got = 1'b1;
    end
    check("t3_done_seen",   got,     1);
    check("t3_done_cycle",  k,       21);
    check("t3_owner_at_done", o_owner, 0);
    @(negedge clk);
    check("t3_owner_new",   o_owner,       1);
    check("t3_busy_clear",  o_switch_busy, 0);
    check("t3_user_done",   ud,            0);
    scan_en = '0;

    // Request toggles back inside DRAIN: owner stays scanner.
    sel_req = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_owner_scan", o_owner, 0);
    scan_en = 4'b0010;
    repeat (3) @(negedge clk);
    sel_req = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_busy", o_switch_busy, 1);
    sel_req = 1'b0;
    @(negedge clk);
    check("t4_busy_clear", o_switch_busy, 0);
    check("t4_owner_kept", o_owner,       0);
    run_count(20, pw, sd, ud);
    check("t4_scan_done_count", sd, 1);
    check("t4_user_done_count", ud, 0);
    scan_en = '0;
    repeat (2) @(negedge clk);

    // Reset at movement cycle 7 of a user-owned movement.
    sel_req = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_owner_user", o_owner, 1);
    user_en = 4'b1000;
    repeat (8) @(negedge clk);
    #2;
    rst_n   = 1'b0;
    sel_req = 1'b0;
    user_en = '0;
    #1;
    check("t5_pwm_in_reset",   o_servo_pwm, 0);
    check("t5_owner_in_reset", o_owner,     0);
    check("t5_done_in_reset",  {o_scan_done, o_user_done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_count(25, pw, sd, ud);
    check("t5_pwm_after",  pw,      0);
    check("t5_done_after", sd + ud, 0);

`ifdef SERVO_ARB_FORCE_SWITCH_EN
    // Forced switch: abort after DRAIN_TIMEOUT ticks without a done pulse.
    scan_en = 4'b0001;
    @(negedge clk);
    sel_req = 1'b1;
    k = 1; got = 1'b0; sd = 0;
    while (!got && k < 30) begin
      @(negedge clk); k++;
      sd += $countones(o_scan_done) + $countones(o_user_done);
      if (o_owner) got = 1'b1;
    end
    check("t6_switched",    got,         1);
    check("t6_abort_cycle", k,           6);
    check("t6_pwm_low",     o_servo_pwm, 0);
    check("t6_no_done",     sd,          0);
    scan_en = '0;
    sel_req = 1'b0;
    repeat (4) @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
